// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs granted round-robin onto a registered CDB.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif
module cdb_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W = `ROB_TAG_LEN + 1,
  localparam int DW = TAG_W + 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            flush_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]   src_tag_i,
  input  logic [NUM_SRC-1:0][31:0]        src_value_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  output logic [DW-1:0]                   cdb_o
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [DW-1:0] mem_q [NUM_SRC][FIFO_DEPTH];
  logic [NUM_SRC-1:0][AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NUM_SRC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] rr_q, rr_d, win;
  logic [DW-1:0] cdb_q, cdb_d;
  logic [NUM_SRC-1:0] push, pop;
  logic found;
  logic [SW:0] idx;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // first non-empty source at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_q} + (SW+1)'(k);
      idx = idx >= (SW+1)'(NUM_SRC) ? idx - (SW+1)'(NUM_SRC) : idx;
      if (!found && cnt_q[idx[SW-1:0]] != '0) begin
        found = 1'b1;
        win = idx[SW-1:0];
      end
    end
  end
  // tag 0 means "no broadcast", so such results are accepted but never stored
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready_o[i] = cnt_q[i] < CW'(FIFO_DEPTH);
      push[i] = src_valid_i[i] & src_ready_o[i] & (|src_tag_i[i]);
      pop[i] = found && win == SW'(i);
      wr_d[i] = push[i] ? inc(wr_q[i]) : wr_q[i];
      rd_d[i] = pop[i] ? inc(rd_q[i]) : rd_q[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    rr_d = found ? (win == SW'(NUM_SRC - 1) ? '0 : win + 1'b1) : rr_q;
    cdb_d = found ? mem_q[win][rd_q[win]] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      cdb_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      cdb_q <= cdb_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= {src_tag_i[i], src_value_i[i]};
  end
  assign cdb_o = cdb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: queue-based reference model feeding a scoreboard checked every cycle on cdb.
module tb_cdb_arbiter;
  localparam int N = 2;
  localparam int D = 2;
  localparam int TW = 4;
  typedef logic [TW+31:0] ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0, flush = 1'b0;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0][TW-1:0] src_tag = '0;
  logic [N-1:0][31:0] src_value = '0;
  logic [N-1:0] src_ready;
  ent_t cdb;
  int checks = 0, failures = 0;
  ent_t mq [N][$];
  ent_t exp_q [$];
  int rr = 0;
  bit started = 0;
  logic [N-1:0] pv = '0;
  logic [N-1:0][TW-1:0] pt = '0;
  logic [N-1:0][31:0] pval = '0;
  always #5 clk = ~clk;
  cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .src_valid_i(src_valid), .src_tag_i(src_tag), .src_value_i(src_value),
    .src_ready_o(src_ready), .cdb_o(cdb)
  );
  // called at posedge+1: drive one cycle, predict the next edge, release accepted producers
  task automatic step(input logic rs, input logic fl);
    ent_t e;
    int w;
    logic [N-1:0] acc;
    reset = rs;
    flush = fl;
    src_valid = pv;
    src_tag = pt;
    src_value = pval;
    for (int i = 0; i < N; i++) begin
      acc[i] = pv[i] && mq[i].size() < D;
      if (started) begin
        checks++;
        if (src_ready[i] !== (mq[i].size() < D)) begin
          failures++;
          $display("FAIL src_ready[%0d] got=%b want=%b t=%0t", i, src_ready[i], mq[i].size() < D, $time);
        end
      end
    end
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
    e = '0;
    if (rs || fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
    end else begin
      if (w >= 0) begin
        e = mq[w].pop_front();
        rr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (acc[i] && pt[i] != '0) mq[i].push_back({pt[i], pval[i]});
    end
    pv = pv & ~acc;
    @(posedge clk);
    exp_q.push_back(e);
    if (rs) started = 1;
    #1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent_t e;
      e = exp_q.pop_front();
      checks++;
      if (cdb !== e) begin
        failures++;
        $display("FAIL cdb got=%h want=%h t=%0t", cdb, e, $time);
      end
    end
  end
  initial begin
    int alu_tag, st_tag;
    @(posedge clk);
    #1;
    step(1, 0);
    pv[1] = 1; pt[1] = 3; pval[1] = 7;
    step(0, 0);
    repeat (3) step(0, 0);
    pv = 2'b11; pt[0] = 1; pval[0] = 5; pt[1] = 2; pval[1] = 10;
    step(0, 0);
    repeat (3) step(0, 0);
    alu_tag = 4;
    st_tag = 8;
    for (int c = 0; c < 6; c++) begin
      if (!pv[1]) begin pv[1] = 1; pt[1] = TW'(alu_tag); pval[1] = 32'(alu_tag * 11); alu_tag++; end
      if (!pv[0] && st_tag <= 9) begin pv[0] = 1; pt[0] = TW'(st_tag); pval[0] = 32'(st_tag * 3); st_tag++; end
      step(0, 0);
    end
    pv = '0;
    repeat (6) step(0, 0);
    pv = 2'b11; pt[0] = 5; pval[0] = 32'h55; pt[1] = 6; pval[1] = 32'h66;
    step(0, 0);
    step(0, 1);
    repeat (3) step(0, 0);
    pv[0] = 1; pt[0] = 0; pval[0] = 32'hDEAD;
    step(0, 0);
    repeat (3) step(0, 0);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 3) != 0) begin
          pv[i] = 1;
          pt[i] = TW'($urandom_range(0, 15));
          pval[i] = $urandom;
        end
      step($urandom_range(0, 150) == 0, $urandom_range(0, 40) == 0);
    end
    pv = '0;
    repeat (6) step(0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
